// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding a UART transmitter through a newd/donetx handshake, one byte in flight at a time.
// Define UART_TXQ_OVF_EN to add the sticky overflow output for dropped writes.
module uart_tx_queue #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count,
    output logic        newd,
    output logic [7:0]  dintx,
    input  logic        donetx,
    output logic        busy
`ifdef UART_TXQ_OVF_EN
    ,
    output logic        overflow
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_LOW = 2'd2
    } state_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    state_t          state_r;
    state_t          state_nxt_s;
    logic [7:0]      mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW:0]     count_r;
    logic [AW:0]     count_nxt_s;
    logic            full_r;
    logic            empty_r;
    logic            newd_r;
    logic            newd_nxt_s;
    logic [7:0]      dintx_r;
    logic [7:0]      dintx_nxt_s;
    logic            busy_r;
    logic            done_q_r;
    logic            rise_s;
    logic            wr_accept_s;
    logic            pop_s;

    // full is the registered pre-edge value, so a write at full is dropped even when a pop happens in the same cycle
    assign wr_accept_s = wr_en & ~full_r;
    assign rise_s      = donetx & ~done_q_r;
    assign count_nxt_s = count_r + {{AW{1'b0}}, wr_accept_s} - {{AW{1'b0}}, pop_s};

    // Byte storage; contents need no reset because pointers and count define validity
    always_ff @(posedge clk) begin
        if (rst && wr_accept_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // State register plus all registered control and status
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            newd_r   <= 1'b0;
            dintx_r  <= 8'h00;
            busy_r   <= 1'b0;
            done_q_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            wr_ptr_r <= wr_accept_s ? wr_ptr_r + AW'(1) : wr_ptr_r;
            rd_ptr_r <= pop_s ? rd_ptr_r + AW'(1) : rd_ptr_r;
            count_r  <= count_nxt_s;
            full_r   <= (count_nxt_s == FULL_CNT);
            empty_r  <= (count_nxt_s == {(AW+1){1'b0}});
            newd_r   <= newd_nxt_s;
            dintx_r  <= dintx_nxt_s;
            busy_r   <= (state_nxt_s != ST_IDLE);
            done_q_r <= donetx;
        end
    end

    // Next-state logic for the transmit handshake
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!empty_r) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (rise_s) begin
                    state_nxt_s = ST_WAIT_LOW;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT_LOW: begin
                if (donetx) begin
                    state_nxt_s = ST_WAIT_LOW;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output logic: pop the head byte on leaving IDLE, hold the request until the frame-done edge
    always_comb begin
        pop_s       = 1'b0;
        newd_nxt_s  = newd_r;
        dintx_nxt_s = dintx_r;
        case (state_r)
            ST_IDLE: begin
                if (!empty_r) begin
                    pop_s       = 1'b1;
                    newd_nxt_s  = 1'b1;
                    dintx_nxt_s = mem_r[rd_ptr_r];
                end else begin
                    newd_nxt_s  = 1'b0;
                end
            end
            ST_REQ: begin
                if (rise_s) begin
                    newd_nxt_s = 1'b0;
                end else begin
                    newd_nxt_s = 1'b1;
                end
            end
            ST_WAIT_LOW: begin
                newd_nxt_s = 1'b0;
            end
            default: begin
                newd_nxt_s = 1'b0;
            end
        endcase
    end

`ifdef UART_TXQ_OVF_EN
    logic overflow_r;

    // Sticky record of any write refused because the queue was full
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r | (wr_en & full_r);
        end
    end

    assign overflow = overflow_r;
`endif

    assign full  = full_r;
    assign empty = empty_r;
    assign count = count_r;
    assign newd  = newd_r;
    assign dintx = dintx_r;
    assign busy  = busy_r;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed self-checking bench for uart_tx_queue with a byte scoreboard standing in for the transmitter.
module tb_uart_tx_queue;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        full;
    logic        empty;
    logic [AW:0] count;
    logic        newd;
    logic [7:0]  dintx;
    logic        donetx;
    logic        busy;
`ifdef UART_TXQ_OVF_EN
    logic        overflow;
`endif

    int checks = 0;
    int errors = 0;
    int mdl_count = 0;
    logic [7:0] sb[$];

    uart_tx_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .newd     (newd),
        .dintx    (dintx),
        .donetx   (donetx),
        .busy     (busy)
`ifdef UART_TXQ_OVF_EN
        ,
        .overflow (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One host write; the model accepts it only if the queue has room
    task automatic write_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        if (mdl_count < DEPTH) begin
            sb.push_back(b);
            mdl_count++;
        end
        tick();
        wr_en = 1'b0;
    endtask

    // Wait (bounded) for a transmit request and compare the presented byte with the scoreboard head
    task automatic wait_newd();
        logic [7:0] exp_b;
        int n;
        n = 0;
        while (newd !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("newd_seen", {31'd0, newd}, 32'd1);
        if (sb.size() > 0) begin
            exp_b = sb.pop_front();
            mdl_count--;
            check("dintx_byte", {24'd0, dintx}, {24'd0, exp_b});
        end else begin
            check("sb_nonempty", 32'd0, 32'd1);
        end
    endtask

    // Emulated transmitter ends the frame with a one-cycle done pulse
    task automatic finish_frame();
        donetx = 1'b1;
        tick();
        check("newd_drop", {31'd0, newd}, 32'd0);
        check("busy_wait", {31'd0, busy}, 32'd1);
        donetx = 1'b0;
        tick();
    endtask

    initial begin
        int pulses;
        rst     = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        donetx  = 1'b0;
        tick();
        tick();
        check("rst_newd",  {31'd0, newd}, 32'd0);
        check("rst_count", {27'd0, count}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full",  {31'd0, full}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_dintx", {24'd0, dintx}, 32'd0);
`ifdef UART_TXQ_OVF_EN
        check("rst_ovf",   {31'd0, overflow}, 32'd0);
`endif
        rst = 1'b1;
        tick();

        // Single byte latency and hold-until-done
        write_byte(8'hA5);
        check("lat_empty", {31'd0, empty}, 32'd0);
        check("lat_newd0", {31'd0, newd}, 32'd0);
        tick();
        check("lat_newd1", {31'd0, newd}, 32'd1);
        wait_newd();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_newd",  {31'd0, newd}, 32'd1);
            check("hold_dintx", {24'd0, dintx}, 32'hA5);
        end
        finish_frame();
        check("idle_busy",  {31'd0, busy}, 32'd0);
        check("idle_empty", {31'd0, empty}, 32'd1);

        // Long done level: one request per byte, second only after donetx falls
        write_byte(8'h11);
        write_byte(8'h22);
        check("wr_pop_count", {27'd0, count}, 32'd1);
        wait_newd();
        donetx = 1'b1;
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (newd === 1'b1) pulses++;
        end
        check("long_done_pulses", pulses, 32'd0);
        check("long_done_busy", {31'd0, busy}, 32'd1);
        check("long_done_count", {27'd0, count}, 32'd1);
        donetx = 1'b0;
        wait_newd();
        finish_frame();

        // Fill to 16 behind an outstanding byte, then drain in order
        write_byte(8'hC3);
        wait_newd();
        for (int i = 0; i < 16; i++) write_byte(8'(i));
        check("fill_count", {27'd0, count}, 32'd16);
        check("fill_full",  {31'd0, full}, 32'd1);
        finish_frame();
        for (int i = 0; i < 16; i++) begin
            wait_newd();
            finish_frame();
        end
        check("drain_empty", {31'd0, empty}, 32'd1);
        check("drain_count", {27'd0, count}, 32'd0);
        check("drain_sb",    sb.size(), 32'd0);

        // Seventeen writes with no drain: the last one is lost
        write_byte(8'hC3);
        wait_newd();
        for (int i = 0; i < 17; i++) write_byte(8'(8'h20 + i));
        check("ovf_count", {27'd0, count}, 32'd16);
        check("ovf_full",  {31'd0, full}, 32'd1);
`ifdef UART_TXQ_OVF_EN
        check("ovf_flag",  {31'd0, overflow}, 32'd1);
`endif
        finish_frame();
        for (int i = 0; i < 16; i++) begin
            wait_newd();
            finish_frame();
        end
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (newd === 1'b1) pulses++;
        end
        check("ovf_no_extra", pulses, 32'd0);
        check("ovf_sb", sb.size(), 32'd0);

        // Reset mid-request with five bytes queued
        for (int i = 0; i < 6; i++) write_byte(8'(8'h40 + i));
        wait_newd();
        check("pre_rst_count", {27'd0, count}, 32'd5);
        check("pre_rst_busy",  {31'd0, busy}, 32'd1);
        rst = 1'b0;
        tick();
        check("mid_rst_newd",  {31'd0, newd}, 32'd0);
        check("mid_rst_count", {27'd0, count}, 32'd0);
        check("mid_rst_empty", {31'd0, empty}, 32'd1);
        check("mid_rst_busy",  {31'd0, busy}, 32'd0);
`ifdef UART_TXQ_OVF_EN
        check("mid_rst_ovf",   {31'd0, overflow}, 32'd0);
`endif
        sb.delete();
        mdl_count = 0;
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (newd === 1'b1) pulses++;
        end
        check("post_rst_quiet", pulses, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, FIFO depth in bytes (power of two, >= 2).
REQ-002 The block SHALL have parameter AW, default $clog2(DEPTH), read/write pointer width.
REQ-003 The block SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous active-low reset, shared with the downstream transmitter.
REQ-005 The block SHALL have port wr_en  input  1  host write strobe, one byte per asserted cycle.
REQ-006 The block SHALL have port wr_data  input  8  host byte.
REQ-007 The block SHALL have port full  output  1  FIFO holds DEPTH bytes.
REQ-008 The block SHALL have port empty  output  1  FIFO holds 0 bytes.
REQ-009 The block SHALL have port count  output  AW+1  bytes currently stored.
REQ-010 The block SHALL have port newd  output  1  transmit request to transmitter.
REQ-011 The block SHALL have port dintx  output  8  byte presented to transmitter.
REQ-012 The block SHALL have port donetx  input  1  transmitter frame-done level (high for one baud-tick period).
REQ-013 The block SHALL have port busy  output  1  high whenever state != IDLE.
REQ-014 The block SHALL have port overflow  output  1  sticky dropped-write flag (present only with UART_TXQ_OVF_EN).

Function
REQ-015 The FIFO SHALL store wr_data at the write pointer when wr_en=1 and full=0; count visible next cycle.
REQ-016 A write with full=1 SHALL be dropped (full sampled before the edge), even if a pop occurs in the same cycle.
REQ-017 Pointers SHALL wrap modulo DEPTH; full/empty SHALL derive from count, never from pointer equality alone.
REQ-018 A simultaneous accepted write and pop SHALL leave count unchanged.
REQ-019 The block SHALL register donetx once (done_q) and detect a rising edge as donetx=1 and done_q=0.
REQ-020 The FSM SHALL have states IDLE, REQ and WAIT_LOW.
REQ-021 In IDLE with empty=0: next edge dintx<=head byte, read pointer++, newd<=1, go REQ.
REQ-022 In REQ: newd and dintx SHALL hold stable until a donetx rising edge; on that edge newd<=0, go WAIT_LOW.
REQ-023 In WAIT_LOW: stay while donetx=1; go IDLE on the first cycle donetx=0.
REQ-024 A donetx rising edge seen in IDLE or WAIT_LOW SHALL be ignored.
REQ-025 Latency: wr_en into an empty idle queue at edge N -> empty=0 after N -> newd=1 after N+1.
REQ-026 At most one byte SHALL be outstanding to the transmitter; the popped byte is no longer counted.
REQ-027 Writes SHALL be accepted in every FSM state.

Reset
REQ-028 With rst=0 at a rising edge: state IDLE, pointers 0, count 0, empty 1, full 0, newd 0, dintx 8'h00, busy 0, done_q 0, overflow 0.
REQ-029 Reset mid-frame SHALL discard all queued bytes and the in-flight byte without emitting newd.

Configuration
REQ-030 With macro UART_TXQ_OVF_EN defined: overflow SHALL be set on a dropped write (REQ-016) and cleared only by reset.
REQ-031 Without UART_TXQ_OVF_EN: the overflow port and its logic SHALL be absent; dropped writes are silent.

Verification
REQ-032 Write 8'hA5 into an idle, empty queue at edge N -> newd=1 and dintx=8'hA5 after N+1; held until donetx rises; newd=0 one cycle after that rise.
REQ-033 Write 16 bytes 0x00..0x0F back-to-back -> full=1, count=16; emulated transmitter receives 0x00..0x0F in order; empty=1 at end.
REQ-034 Write 17 bytes with no drain -> 17th byte lost, count=16; overflow=1 with UART_TXQ_OVF_EN, port absent without it.
REQ-035 Hold donetx=1 for 50 cycles while 2 bytes are queued -> exactly one newd pulse per byte; second request starts only after donetx falls.
REQ-036 Assert rst=0 while in REQ with 5 bytes queued -> next cycle newd=0, count=0, empty=1, busy=0; no further requests are issued.
